button_event_gen: RTL and testbench
===================================

// Module: button_event_gen
// PURPOSE
//   Consumes the 4-bit debounced button levels and turns them into discrete
//   move events for the game FSM: one event per press, plus auto-repeat
//   events while a single button stays held.
//   Events leave through a single-entry valid/ready holding register.
//   Sits between the button debouncer and the cursor/turn logic.
// PARAMETERS
//   HOLD_CYCLES    25_000_000  cycles a button is held after its press event before the first repeat (0.5 s @ 50 MHz)
//   REPEAT_CYCLES  10_000_000  cycles between successive repeat events
//   CNT_W          32          hold/repeat counter width; must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   reset       in   1  asynchronous, active-low reset (0 = reset asserted)
//   btn         in   4  debounced button levels, 1 = pressed
//   evt_valid   out  1  event register holds an unconsumed event
//   evt_ready   in   1  consumer accepts the event when evt_valid && evt_ready at posedge
//   evt_code    out  2  index of the pressed button (bit position in btn)
//   evt_repeat  out  1  0 = initial press event, 1 = auto-repeat event
//   evt_drop    out  1  1-cycle pulse: a generated event was lost because the register was full
//   multi_err   out  1  1-cycle pulse: more than one button seen at the same time
// BEHAVIOUR
//   Reset (async, reset==0): state=IDLE, counter=0, latched pattern=0; all outputs 0.
//   Events are "generated" internally at a posedge. Latency is 1 cycle: btn sampled at edge k,
//     so evt_valid/code/repeat show the new event after edge k.
//   FSM states: IDLE, HOLD, REPEAT, LOCKOUT.
//   - IDLE: btn==0 -> stay.
//       btn one-hot -> generate event (repeat=0, code=index), latch pattern, counter<=0, go to HOLD.
//       btn with >=2 bits set -> multi_err pulse, go to LOCKOUT, no event.
//   - HOLD: btn==latched -> if counter==HOLD_CYCLES-1, generate event (repeat=1), counter<=0,
//       go to REPEAT; else counter++.
//       btn==0 -> IDLE.
//       Any other btn value -> LOCKOUT (multi_err pulse if >=2 bits set).
//   - REPEAT: same as HOLD, but with REPEAT_CYCLES; a repeat event keeps the FSM in REPEAT.
//   - LOCKOUT: no events; stay until btn==0, then go to IDLE. A new press must begin from all-released.
//   Event register (single entry):
//   - Consume: evt_valid && evt_ready at posedge clears evt_valid, unless a new event is generated on the same edge.
//   - Same-edge consume and new event: evt_valid stays 1, code/repeat take the new event, no drop.
//   - New event while evt_valid==1 and evt_ready==0: new event discarded; code/repeat unchanged;
//     evt_drop pulses for 1 cycle. FSM and counter still advance as if the event was delivered.
//   - code/repeat are stable while evt_valid==1 and not consumed.
//   - evt_drop and multi_err are high for exactly one cycle per occurrence, registered.
//   Counter arithmetic: unsigned CNT_W bits, cleared on every state entry. It never wraps,
//     because it is compared for equality and cleared at the limit.
//   Reset mid-operation: all state and outputs clear at once. If a single button is still
//     held when reset releases, it counts as a fresh press: initial event on the first edge.
// TESTING  (HOLD_CYCLES=8, REPEAT_CYCLES=4, evt_ready=1 unless stated)
//   1 btn=0001 for 3 cycles, then 0 -> exactly one event after edge k: code=0, repeat=0,
//     evt_valid high for 1 cycle.
//   2 btn=0100 held 20 cycles from edge k -> events at k (repeat=0) and at k+8, k+12, k+16
//     (repeat=1), all code=2; none after release.
//   3 evt_ready=0, btn=0010 held 10 cycles -> evt_valid=1, code=1, repeat=0 held;
//     evt_drop pulses once at edge k+8; code stays 1, repeat stays 0.
//   4 btn=0011 -> multi_err pulse, no event. Then btn=0001 with no release -> no event.
//     Then btn=0, then btn=0001 -> event code=0.
//   5 reset=0 mid-HOLD with btn=1000 -> all outputs 0 immediately. Release reset with btn=1000
//     -> event code=3, repeat=0 on the next edge.
//   6 evt_valid=1 and evt_ready=1 on the same edge as a repeat event -> evt_valid stays 1,
//     repeat=1, evt_drop=0.

Source files
------------

// File: rtl/button_event_gen.sv
// Turns debounced button levels into press and auto-repeat move events,
// delivered through a single-entry valid/ready holding register.
module button_event_gen #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic       evt_repeat,
  output logic       evt_drop,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    REPEAT  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, limit;
  logic [3:0]       latched;
  logic             btn_multi, btn_one;
  logic             gen, gen_rep, multi_nxt;
  logic [1:0]       gen_code;

  // Clearing the lowest set bit leaves a nonzero value only if two or more bits were set.
  assign btn_multi = (btn & (btn - 4'd1)) != 4'd0;
  assign btn_one   = (btn != 4'd0) && !btn_multi;

  function automatic logic [1:0] btn_index(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  assign gen_code = btn_index((state == IDLE) ? btn : latched);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_nxt = state;
    cnt_nxt   = cnt;
    limit     = HOLD_LAST;
    gen       = 1'b0;
    gen_rep   = 1'b0;
    multi_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_one) begin
          gen       = 1'b1;
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (btn_multi) begin
          multi_nxt = 1'b1;
          state_nxt = LOCKOUT;
          cnt_nxt   = '0;
        end
      end
      HOLD, REPEAT: begin
        limit = (state == HOLD) ? HOLD_LAST : REPEAT_LAST;
        if (btn == latched) begin
          if (cnt == limit) begin
            gen       = 1'b1;
            gen_rep   = 1'b1;
            state_nxt = REPEAT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (btn == 4'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          multi_nxt = btn_multi;
          state_nxt = LOCKOUT;
          cnt_nxt   = '0;
        end
      end
      LOCKOUT: begin
        if (btn == 4'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      latched    <= 4'd0;
      evt_valid  <= 1'b0;
      evt_code   <= 2'd0;
      evt_repeat <= 1'b0;
      evt_drop   <= 1'b0;
      multi_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      multi_err <= multi_nxt;
      evt_drop  <= 1'b0;
      if (state == IDLE && btn_one) latched <= btn;

      // A full register that is being drained on this edge can take the new event directly.
      if (gen) begin
        if (!evt_valid || evt_ready) begin
          evt_valid  <= 1'b1;
          evt_code   <= gen_code;
          evt_repeat <= gen_rep;
        end else begin
          evt_drop <= 1'b1;
        end
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: expected events are queued with their
// delivery cycle and popped when the consumer handshake is observed.
module tb_button_event_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       evt_ready = 1'b1;
  logic       evt_valid, evt_repeat, evt_drop, multi_err;
  logic [1:0] evt_code;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int k;

  typedef struct {
    logic [1:0] code;
    logic       rep;
    int         at;
  } exp_t;

  exp_t q[$];

  button_event_gen #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_repeat(evt_repeat),
    .evt_drop  (evt_drop),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input logic [1:0] code, input logic rep, input int at);
    exp_t e;
    e.code = code;
    e.rep  = rep;
    e.at   = at;
    q.push_back(e);
  endtask

  // Each handshake seen here is one delivered event; an empty queue yields at=-1 and fails.
  always @(negedge clk) begin
    exp_t e;
    if (reset && evt_valid && evt_ready) begin
      e.code = 2'd0;
      e.rep  = 1'b0;
      e.at   = -1;
      if (q.size() != 0) e = q.pop_front();
      check("sb_code",   32'(evt_code),   32'(e.code));
      check("sb_repeat", 32'(evt_repeat), 32'(e.rep));
      check("sb_cycle",  cyc,             e.at);
    end
  end

  initial begin
    tick(3);
    check("rst_valid",  32'(evt_valid),  0);
    check("rst_code",   32'(evt_code),   0);
    check("rst_repeat", 32'(evt_repeat), 0);
    check("rst_drop",   32'(evt_drop),   0);
    check("rst_multi",  32'(multi_err),  0);
    reset = 1'b1;
    tick(2);

    // 1: short press gives one initial event, valid for one cycle
    btn = 4'b0001;
    expect_evt(2'd0, 1'b0, cyc + 1);
    tick();
    check("t1_valid", 32'(evt_valid), 1);
    tick();
    check("t1_one_cycle", 32'(evt_valid), 0);
    tick();
    btn = 4'd0;
    tick(3);

    // 2: long hold gives press then repeats at +8, +12, +16; none after release
    btn = 4'b0100;
    k = cyc + 1;
    expect_evt(2'd2, 1'b0, k);
    expect_evt(2'd2, 1'b1, k + 8);
    expect_evt(2'd2, 1'b1, k + 12);
    expect_evt(2'd2, 1'b1, k + 16);
    tick(20);
    btn = 4'd0;
    tick(6);
    check("t2_idle_after", 32'(evt_valid), 0);

    // 3: stalled consumer, repeat event is dropped and the held event is untouched
    evt_ready = 1'b0;
    btn = 4'b0010;
    k = cyc + 1;
    tick();
    check("t3_valid",  32'(evt_valid),  1);
    check("t3_code",   32'(evt_code),   1);
    check("t3_repeat", 32'(evt_repeat), 0);
    tick(7);
    check("t3_no_early_drop", 32'(evt_drop), 0);
    tick();
    check("t3_drop",        32'(evt_drop),   1);
    check("t3_valid_held",  32'(evt_valid),  1);
    check("t3_code_held",   32'(evt_code),   1);
    check("t3_repeat_held", 32'(evt_repeat), 0);
    tick();
    check("t3_drop_once", 32'(evt_drop), 0);
    btn = 4'd0;
    evt_ready = 1'b1;
    expect_evt(2'd1, 1'b0, cyc);
    tick();
    check("t3_drained", 32'(evt_valid), 0);
    tick(2);

    // 4: chord locks out until full release
    btn = 4'b0011;
    tick();
    check("t4_multi",    32'(multi_err), 1);
    check("t4_no_event", 32'(evt_valid), 0);
    btn = 4'b0001;
    tick();
    check("t4_multi_once", 32'(multi_err), 0);
    tick(2);
    check("t4_locked", 32'(evt_valid), 0);
    btn = 4'd0;
    tick();
    btn = 4'b0001;
    expect_evt(2'd0, 1'b0, cyc + 1);
    tick();
    check("t4_fresh_press", 32'(evt_valid), 1);
    tick();
    btn = 4'b0011;
    tick();
    check("t4_hold_multi",    32'(multi_err), 1);
    check("t4_hold_no_event", 32'(evt_valid), 0);
    btn = 4'd0;
    tick(2);

    // 5: async reset mid-hold, then a still-held button is a fresh press
    evt_ready = 1'b0;
    btn = 4'b1000;
    tick();
    check("t5_valid", 32'(evt_valid), 1);
    check("t5_code",  32'(evt_code),  3);
    tick(2);
    reset = 1'b0;
    #1;
    check("t5_rst_valid",  32'(evt_valid),  0);
    check("t5_rst_code",   32'(evt_code),   0);
    check("t5_rst_repeat", 32'(evt_repeat), 0);
    check("t5_rst_drop",   32'(evt_drop),   0);
    check("t5_rst_multi",  32'(multi_err),  0);
    tick(2);
    evt_ready = 1'b1;
    reset = 1'b1;
    expect_evt(2'd3, 1'b0, cyc + 1);
    tick();
    check("t5_repress_valid",  32'(evt_valid),  1);
    check("t5_repress_code",   32'(evt_code),   3);
    check("t5_repress_repeat", 32'(evt_repeat), 0);
    btn = 4'd0;
    tick(3);

    // 6: consume and repeat on the same edge keeps valid with the new event
    evt_ready = 1'b0;
    btn = 4'b0001;
    k = cyc + 1;
    tick();
    tick(7);
    evt_ready = 1'b1;
    expect_evt(2'd0, 1'b0, cyc);
    expect_evt(2'd0, 1'b1, cyc + 1);
    tick();
    check("t6_valid",   32'(evt_valid),  1);
    check("t6_repeat",  32'(evt_repeat), 1);
    check("t6_no_drop", 32'(evt_drop),   0);
    btn = 4'd0;
    tick();
    check("t6_drained", 32'(evt_valid), 0);
    tick(2);

    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
